// File: rtl/out_port_arb.sv
// Round-robin output-port arbiter with packet lock and crossbar select.
// Define OUT_ARB_MCAST_PRIO_EN to scan multicast requesters ahead of unicast in IDLE.
module out_port_arb #(
   parameter int unsigned NPORT  = 5,
   parameter int unsigned PW     = 3,
   parameter int unsigned PORTID = 4
) (
   input  logic                       clk,
   input  logic                       rst_,
   input  logic [NPORT-1:0]           req,
   input  logic [NPORT*PW-1:0]        dst,
   input  logic [2*NPORT-1:0]         mode,
   input  logic [NPORT-1:0]           tail,
   input  logic                       out_ready,
   output logic [NPORT-1:0]           grt,
   output logic [NPORT-1:0]           sel,
   output logic [NPORT-1:0]           multab_ct,
   output logic                       locked,
   output logic [$clog2(NPORT)-1:0]   owner
);

   localparam int unsigned IW = $clog2(NPORT);
   localparam logic [1:0] MODE_UC = 2'b01;
   localparam logic [1:0] MODE_MC = 2'b10;

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t            state, state_nxt;
   logic [IW-1:0]     ptr, ptr_nxt, owner_nxt, rr_idx;
   logic [IW:0]       rr_sum;
   logic              rr_found;
   logic [NPORT-1:0]  elig, mc_elig, scan, rot;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
      return (32'(i) == NPORT - 1) ? '0 : i + 1'b1;
   endfunction

   function automatic logic [NPORT-1:0] onehot(input logic [IW-1:0] i);
      return {{(NPORT-1){1'b0}}, 1'b1} << i;
   endfunction

   // Per-port eligibility for this output
   always_comb begin
      elig    = '0;
      mc_elig = '0;
      for (int unsigned i = 0; i < NPORT; i++) begin
         mc_elig[i] = req[i] & (mode[2*i +: 2] == MODE_MC);
         elig[i]    = mc_elig[i] |
                      (req[i] & (mode[2*i +: 2] == MODE_UC) & (dst[i*PW +: PW] == PW'(PORTID)));
      end
   end

`ifdef OUT_ARB_MCAST_PRIO_EN
   assign scan = (|mc_elig) ? mc_elig : elig;
`else
   assign scan = elig;
`endif

   // Rotate so that bit 0 is the pointer position, then pick the first set bit
   assign rot = NPORT'({scan, scan} >> ptr);

   always_comb begin
      rr_found = 1'b0;
      rr_sum   = '0;
      for (int unsigned k = 0; k < NPORT; k++) begin
         if (!rr_found && rot[k]) begin
            rr_found = 1'b1;
            rr_sum   = {1'b0, ptr} + (IW+1)'(k);
         end
      end
      if (rr_sum >= (IW+1)'(NPORT)) rr_sum = rr_sum - (IW+1)'(NPORT);
   end

   assign rr_idx = rr_sum[IW-1:0];

   // Next state, pointer/owner update and combinational grant
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      grt       = '0;
      case (state)
         S_IDLE: begin
            if (rr_found) begin
               grt = onehot(rr_idx);
               if (out_ready) begin
                  if (tail[rr_idx]) begin
                     ptr_nxt = wrap_inc(rr_idx);
                  end else begin
                     state_nxt = S_LOCKED;
                     owner_nxt = rr_idx;
                  end
               end
            end
         end
         S_LOCKED: begin
            if (elig[owner]) begin
               grt = onehot(owner);
               if (out_ready && tail[owner]) begin
                  state_nxt = S_IDLE;
                  ptr_nxt   = wrap_inc(owner);
               end
            end
         end
      endcase
   end

   assign multab_ct = mc_elig & ~grt;
   assign locked    = (state == S_LOCKED);

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= S_IDLE;
         ptr   <= '0;
         owner <= '0;
         sel   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
         sel   <= grt & {NPORT{out_ready}};
      end
   end

endmodule

// File: tb/tb_out_port_arb.sv
// Directed bench for out_port_arb (NPORT=5, PW=3, PORTID=4).
module tb_out_port_arb;

   localparam logic [1:0] UC = 2'b01;
   localparam logic [1:0] MC = 2'b10;

   logic        clk = 1'b0;
   logic        rst_;
   logic [4:0]  req;
   logic [14:0] dst;
   logic [9:0]  mode;
   logic [4:0]  tail;
   logic        out_ready;
   logic [4:0]  grt, sel, multab_ct;
   logic        locked;
   logic [2:0]  owner;

   int vectors     = 0;
   int miscompares = 0;

   out_port_arb #(.NPORT(5), .PW(3), .PORTID(4)) dut (
      .clk(clk), .rst_(rst_), .req(req), .dst(dst), .mode(mode), .tail(tail),
      .out_ready(out_ready), .grt(grt), .sel(sel), .multab_ct(multab_ct),
      .locked(locked), .owner(owner)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      req = '0; dst = '0; mode = '0; tail = '0;
   endtask

   task automatic setp(input int i, input logic [1:0] m, input logic [2:0] d, input logic t);
      req[i] = 1'b1; mode[2*i +: 2] = m; dst[3*i +: 3] = d; tail[i] = t;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   initial begin
      rst_ = 1'b0; out_ready = 1'b1; clr();
      #2;
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_owner", 32'(owner), 32'h0);
      chk("rst_grt_idle", 32'(grt), 32'h0);
      chk("rst_multab", 32'(multab_ct), 32'h0);
      setp(1, UC, 4, 1); setp(3, UC, 4, 1); #1;
      chk("rst_grt_comb", 32'(grt), 32'b00010);
      clr(); #1;
      rst_ = 1'b1;
      tick();

      // unicast fairness: ports 0,2,3 single-flit packets
      setp(0, UC, 4, 1); setp(2, UC, 4, 1); setp(3, UC, 4, 1); #1;
      chk("rr_grt0", 32'(grt), 32'b00001); tick();
      chk("rr_sel0", 32'(sel), 32'b00001);
      chk("rr_grt1", 32'(grt), 32'b00100); tick();
      chk("rr_sel1", 32'(sel), 32'b00100);
      chk("rr_grt2", 32'(grt), 32'b01000); tick();
      chk("rr_sel2", 32'(sel), 32'b01000);
      chk("rr_grt3", 32'(grt), 32'b00001); tick();
      chk("rr_sel3", 32'(sel), 32'b00001);
      chk("rr_locked", 32'(locked), 32'h0);
      clr(); tick();
      chk("idle_sel", 32'(sel), 32'h0);

      // filtering: wrong destination and reserved mode
      setp(1, UC, 3, 1); setp(2, 2'b11, 4, 1); #1;
      chk("filt_grt", 32'(grt), 32'h0);
      chk("filt_multab", 32'(multab_ct), 32'h0);
      tick();
      chk("filt_sel", 32'(sel), 32'h0);
      clr();

      // packet lock: port 2 sends 4 flits, port 0 waits (ptr=1)
      setp(2, UC, 4, 0); setp(0, UC, 4, 1); #1;
      chk("lock_head_grt", 32'(grt), 32'b00100); tick();
      chk("lock_locked1", 32'(locked), 32'h1);
      chk("lock_owner", 32'(owner), 32'h2);
      chk("lock_sel1", 32'(sel), 32'b00100);
      for (int f = 2; f <= 3; f++) begin
         #1;
         chk("lock_body_grt", 32'(grt), 32'b00100);
         chk("lock_body_multab", 32'(multab_ct), 32'h0);
         tick();
         chk("lock_body_locked", 32'(locked), 32'h1);
      end
      tail[2] = 1'b1; #1;
      chk("lock_tail_grt", 32'(grt), 32'b00100); tick();
      chk("lock_unlocked", 32'(locked), 32'h0);
      chk("lock_tail_sel", 32'(sel), 32'b00100);
      req[2] = 1'b0; #1;
      chk("lock_next_grt", 32'(grt), 32'b00001); tick();
      chk("lock_next_sel", 32'(sel), 32'b00001);
      clr();

      // backpressure and owner bubbles (ptr=1)
      setp(1, UC, 4, 0); setp(0, UC, 4, 1); #1;
      chk("bp_head_grt", 32'(grt), 32'b00010); tick();
      chk("bp_owner", 32'(owner), 32'h1);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("bp_stall_grt", 32'(grt), 32'b00010); tick();
         chk("bp_stall_sel", 32'(sel), 32'h0);
         chk("bp_stall_locked", 32'(locked), 32'h1);
      end
      out_ready = 1'b1; req[1] = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("bp_bubble_grt", 32'(grt), 32'h0); tick();
         chk("bp_bubble_sel", 32'(sel), 32'h0);
         chk("bp_bubble_locked", 32'(locked), 32'h1);
      end
      req[1] = 1'b1; tail[1] = 1'b1; #1;
      chk("bp_tail_grt", 32'(grt), 32'b00010); tick();
      chk("bp_tail_sel", 32'(sel), 32'b00010);
      chk("bp_tail_locked", 32'(locked), 32'h0);
      clr();

      // multicast contention against a locked unicast owner (ptr=2)
      setp(3, UC, 4, 0); #1;
      chk("mc_head_grt", 32'(grt), 32'b01000); tick();
      chk("mc_owner", 32'(owner), 32'h3);
      setp(0, MC, 0, 1);
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("mc_hold_grt", 32'(grt), 32'b01000);
         chk("mc_hold_multab", 32'(multab_ct), 32'b00001);
         tick();
      end
      tail[3] = 1'b1; #1;
      chk("mc_tail_multab", 32'(multab_ct), 32'b00001); tick();
      chk("mc_tail_locked", 32'(locked), 32'h0);
      req[3] = 1'b0; #1;
      chk("mc_win_grt", 32'(grt), 32'b00001);
      chk("mc_win_multab", 32'(multab_ct), 32'h0);
      tick();
      chk("mc_win_sel", 32'(sel), 32'b00001);
      clr();

      // reset during flit 2 of a packet (ptr=1)
      setp(4, UC, 4, 0); #1;
      chk("rm_head_grt", 32'(grt), 32'b10000); tick();
      chk("rm_locked", 32'(locked), 32'h1);
      chk("rm_sel", 32'(sel), 32'b10000);
      rst_ = 1'b0; #1;
      chk("rm_locked_clr", 32'(locked), 32'h0);
      chk("rm_sel_clr", 32'(sel), 32'h0);
      chk("rm_owner_clr", 32'(owner), 32'h0);
      clr(); setp(0, UC, 4, 1); setp(3, UC, 4, 1); #1;
      chk("rm_ptr_zero", 32'(grt), 32'b00001);
      rst_ = 1'b1;

      // multicast priority option with ptr=0
      clr(); setp(0, UC, 4, 1); setp(3, MC, 1, 1); #1;
`ifdef OUT_ARB_MCAST_PRIO_EN
      chk("prio_grt", 32'(grt), 32'b01000);
      chk("prio_multab", 32'(multab_ct), 32'h0);
      tick();
      chk("prio_sel", 32'(sel), 32'b01000);
`else
      chk("prio_grt", 32'(grt), 32'b00001);
      chk("prio_multab", 32'(multab_ct), 32'b01000);
      tick();
      chk("prio_sel", 32'(sel), 32'b00001);
`endif
      clr(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
